// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg : shared opcode, state and ALU-op encodings for the CPU core  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SUB = 4'h6,
    OP_SBC = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_JC  = 4'hA,
    OP_JN  = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH_OP  = 3'd0,
    S_FETCH_ARG = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_MEM_WAIT  = 3'd4,
    S_ALU_WB    = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cpu_control.sv
// +----------------------------------------------------------------------+
// | cpu_control : fetch/decode/execute sequencer of the 8-bit acc CPU     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cpu_control
  import cpu_pkg::*;
(
  input  logic       _iClk,
  input  logic       _iReset,
  input  logic [7:0] _iInstMemData,
  input  logic [7:0] _iDataMemRData,
  input  logic [7:0] _iAluRes,
  input  logic       _iAluFlagCarry,
  input  logic       _iAluFlagZero,
  input  logic       _iAluFlagNeg,
  output logic [7:0] _oInstMemAddr,
  output logic [7:0] _oDataMemAddr,
  output logic [7:0] _oDataMemWData,
  output logic       _oDataMemWrite,
  output logic [7:0] _oAccumulator,
  output logic [7:0] _oAluB,
  output logic       _oAluC,
  output logic       _oAluEn,
  output logic       _oAluOp,
  output logic       _oHalted
);

  state_t     state, state_nxt;
  opcode_t    ir, ir_nxt;
  logic [7:0] pc, pc_nxt;
  logic [7:0] arg, arg_nxt;
  logic [7:0] acc, acc_nxt;
  logic       is_alu, use_carry, is_sub;

  // Only the opcode nibble is kept; the low nibble of the opcode byte is don't-care.
  always_comb begin
    is_alu    = 1'b0;
    use_carry = 1'b0;
    is_sub    = 1'b0;
    case (ir)
      OP_ADD: is_alu = 1'b1;
      OP_ADC: begin is_alu = 1'b1; use_carry = 1'b1; end
      OP_SUB: begin is_alu = 1'b1; is_sub = 1'b1; end
      OP_SBC: begin is_alu = 1'b1; use_carry = 1'b1; is_sub = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc;
    arg_nxt   = arg;
    acc_nxt   = acc;
    case (state)
      S_FETCH_OP: begin
        pc_nxt    = pc + 8'd1;
        state_nxt = S_FETCH_ARG;
      end
      S_FETCH_ARG: begin
        ir_nxt    = opcode_t'(_iInstMemData[7:4]);
        pc_nxt    = pc + 8'd1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        arg_nxt   = _iInstMemData;
        state_nxt = S_FETCH_OP;
        case (ir)
          OP_LDI: acc_nxt = _iInstMemData;
          OP_JMP: pc_nxt  = _iInstMemData;
          OP_JZ:  if (_iAluFlagZero)  pc_nxt = _iInstMemData;
          OP_JC:  if (_iAluFlagCarry) pc_nxt = _iInstMemData;
          OP_JN:  if (_iAluFlagNeg)   pc_nxt = _iInstMemData;
          OP_HLT: state_nxt = S_HALT;
          OP_LDA, OP_STA, OP_ADD, OP_ADC, OP_SUB, OP_SBC: state_nxt = S_EXEC;
          default: ;
        endcase
      end
      S_EXEC: begin
        state_nxt = (ir == OP_STA) ? S_FETCH_OP : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (is_alu) begin
          state_nxt = S_ALU_WB;
        end else begin
          acc_nxt   = _iDataMemRData;
          state_nxt = S_FETCH_OP;
        end
      end
      S_ALU_WB: begin
        acc_nxt   = _iAluRes;
        state_nxt = S_FETCH_OP;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH_OP;
    endcase
  end

  always_ff @(posedge _iClk) begin
    if (_iReset) begin
      state <= S_FETCH_OP;
      ir    <= OP_NOP;
      pc    <= 8'h00;
      arg   <= 8'h00;
      acc   <= 8'h00;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc    <= pc_nxt;
      arg   <= arg_nxt;
      acc   <= acc_nxt;
    end
  end

  assign _oInstMemAddr  = pc;
  assign _oDataMemAddr  = arg;
  assign _oDataMemWData = acc;
  assign _oAccumulator  = acc;
  assign _oAluB         = _iDataMemRData;
  assign _oAluC         = use_carry & _iAluFlagCarry;
  assign _oAluOp        = is_sub ? ALU_OP_SUB : ALU_OP_ADD;

  // Strobes are masked by reset so an abandoned instruction never leaks a write or ALU op.
  assign _oDataMemWrite = (state == S_EXEC) && (ir == OP_STA) && !_iReset;
  assign _oAluEn        = (state == S_MEM_WAIT) && is_alu && !_iReset;
  assign _oHalted       = (state == S_HALT) && !_iReset;

endmodule

`default_nettype wire

// File: doc/cpu_control.md
# cpu_control

Fetch/decode/execute sequencer for the 8-bit accumulator CPU. Sits directly upstream of the ALU. It owns:
- the program counter, the instruction and operand registers, and the accumulator;
- the instruction- and data-memory address/write strobes;
- the ALU enable, op and carry-in.

It consumes the registered ALU result and flags. Accumulator feeds ALU `_iA`.

## Interface
Parameters:
- none (widths fixed at 8 bits by the ISA)

Ports:
- `_iClk`  in  1  system clock; one clock domain.
- `_iReset`  in  1  reset, synchronous and active-high.
- `_iInstMemData`  in  8  instruction byte; valid the cycle after `_oInstMemAddr` is presented.
- `_iDataMemRData`  in  8  data byte; valid the cycle after `_oDataMemAddr` is presented.
- `_iAluRes`  in  8  ALU result; valid the cycle after `_oAluEn`.
- `_iAluFlagCarry`, `_iAluFlagZero`, `_iAluFlagNeg`  in  1 each  ALU flags; held by the ALU since its last enabled op.
- `_oInstMemAddr`  out  8  instruction address = PC.
- `_oDataMemAddr`  out  8  data address = operand register.
- `_oDataMemWData`  out  8  = accumulator.
- `_oDataMemWrite`  out  1  write strobe; single cycle.
- `_oAccumulator`  out  8  to ALU `_iA`.
- `_oAluB`  out  8  = `_iDataMemRData`.
- `_oAluC`  out  1  carry-in.
- `_oAluEn`  out  1  ALU enable; single cycle.
- `_oAluOp`  out  1  0 = add, 1 = subtract.
- `_oHalted`  out  1  high while in HALT.

## Operation
Every instruction is two bytes: opcode byte (upper nibble decoded, lower nibble ignored), then operand byte.

Opcodes, defined in `cpu_pkg` as `opcode_t`:
- 0x0 NOP.
- 0x1 LDI: acc ← imm.
- 0x2 LDA: acc ← mem[a].
- 0x3 STA: mem[a] ← acc.
- 0x4 ADD: C = 0, op = 0.
- 0x5 ADC: C = flagCarry, op = 0.
- 0x6 SUB: C = 0, op = 1.
- 0x7 SBC: C = flagCarry, op = 1.
- 0x8 JMP.
- 0x9 JZ, 0xA JC, 0xB JN: jump if the named flag is set.
- 0xF HLT.
- 0xC–0xE execute as NOP.

Flag rules:
- Only ALU ops change flags; LDI/LDA/STA leave them untouched.
- Jumps test the flags as held by the ALU.

State machine (`state_t` in `cpu_pkg`):
- FETCH_OP: instAddr = PC; PC ← PC+1 → FETCH_ARG.
- FETCH_ARG: IR ← `_iInstMemData`; instAddr = PC; PC ← PC+1 → DECODE.
- DECODE: ARG ← `_iInstMemData`; then by opcode:
  - NOP → FETCH_OP.
  - LDI: acc ← data → FETCH_OP.
  - JMP / taken Jcc: PC ← data → FETCH_OP.
  - Untaken Jcc → FETCH_OP.
  - HLT → HALT.
  - Otherwise → EXEC.
- EXEC: dataAddr = ARG.
  - STA: `_oDataMemWrite` = 1 → FETCH_OP.
  - LDA/ALU ops → MEM_WAIT.
- MEM_WAIT:
  - LDA: acc ← `_iDataMemRData` → FETCH_OP.
  - ALU op: `_oAluEn` = 1 with op/C per opcode → ALU_WB.
- ALU_WB: acc ← `_iAluRes` → FETCH_OP.
- HALT: terminal; `_oHalted` = 1; no strobes; only reset exits.

Arithmetic and boundary rules:
- PC arithmetic is mod 256. An opcode at 0xFF fetches its operand from 0x00.
- Jump target is absolute. A jump to self from HLT-free code loops forever; this is legal.

## Timing
- Reset values:
  - PC = 0x00, IR = 0x00, ARG = 0x00, acc = 0x00; state = FETCH_OP.
  - `_oDataMemWrite` = 0, `_oAluEn` = 0, `_oHalted` = 0.
  - `_oInstMemAddr` = 0x00, `_oDataMemAddr` = 0x00, `_oAccumulator` = 0x00.
- Strobes (`_oDataMemWrite`, `_oAluEn`) are decoded from state and gated with `!_iReset`. A reset in EXEC or MEM_WAIT therefore never emits a write or ALU enable in the reset cycle.
- Reset mid-instruction abandons it; no partial acc/PC update.
- The first fetch (address 0x00) occurs in the first cycle after reset deasserts.
- Cycles per instruction, counted from FETCH_OP to the next FETCH_OP:
  - NOP/LDI/JMP/Jcc: 3.
  - STA: 4.
  - LDA: 5.
  - ALU ops: 6.
- Updated values are visible:
  - acc on `_oAccumulator`: the cycle after DECODE (LDI), after MEM_WAIT (LDA), or after ALU_WB (ALU ops).
  - A jump's PC: at the next FETCH_OP.
- `_oDataMemWData` = acc during the STA write cycle.
- No back-pressure: memories and ALU have fixed one-cycle latency.

## Structure
- `cpu_pkg` holds:
  - `opcode_t` (4-bit enum, values above);
  - `state_t`;
  - constants `ALU_OP_ADD` = 0 and `ALU_OP_SUB` = 1, shared with the ALU.
- Single module, no sub-modules. PC, IR, ARG and acc are plain registers in the same file.
- `tp1` instantiates `cpu_control` beside the ALU.

## Test plan
- Reset check: hold `_iReset` for 3 cycles mid-ADD (state MEM_WAIT) → `_oAluEn` stays 0; after release, `_oInstMemAddr` = 0x00 and acc = 0x00.
- Program LDI 0x05; ADD [0x10] with mem[0x10] = 0x03; STA [0x20] → ALU sees A = 0x05, B = 0x03, C = 0, op = 0; mem[0x20] written 0xXX = `_iAluRes` (model returns 0x08); total 13 cycles to the STA write.
- ADC after an ALU that set carry = 1 → `_oAluC` = 1. SBC with carry = 0 → `_oAluOp` = 1, `_oAluC` = 0.
- Jumps with Zero = 1:
  - JZ 0x40 → next `_oInstMemAddr` = 0x40.
  - JC 0x40 (Carry = 0) → next fetch address = PC of JC + 2.
- Wrap: opcode LDI at 0xFF, operand 0x7E at 0x00 → acc = 0x7E; next fetch at 0x01.
- Halt: HLT → `_oHalted` = 1 and PC frozen for 20 cycles with no strobes. Opcode 0xD → behaves as NOP (3 cycles, acc unchanged).
